// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin wishbone arbiter sharing the L2 between the L1 I-cache and D-cache.
// One line transaction is granted at a time, and a one-cycle gap follows every completed grant.
module l2_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int SEL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [DATA_W-1:0] i_dat_m,
    input  logic [SEL_W-1:0]  i_sel,
    output logic              i_ack,
    output logic              i_rty,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_dat_m,
    input  logic [SEL_W-1:0]  d_sel,
    output logic              d_ack,
    output logic              d_rty,
    output logic [DATA_W-1:0] dat_s,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_m,
    output logic [SEL_W-1:0]  s_sel,
    input  logic [DATA_W-1:0] s_dat_s,
    input  logic              s_ack,
    input  logic              s_rty,
    output logic [15:0]       conflict_count
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, GAP} state_t;

    state_t      r_state, w_next;
    logic        r_pri;
    logic [15:0] r_conflict_count;
    logic        w_req_i, w_req_d, w_gi, w_gd, w_conflict, w_unused;

    assign w_req_i    = i_cyc & i_stb;
    assign w_req_d    = d_cyc & d_stb;
    assign w_gi       = r_state == GNT_I;
    assign w_gd       = r_state == GNT_D;
    assign w_conflict = (r_state == IDLE) & w_req_i & w_req_d;
    assign w_unused   = s_rty;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_conflict ? (r_pri ? GNT_I : GNT_D) :
                              w_req_d ? GNT_D : w_req_i ? GNT_I : IDLE;
            GNT_I:   w_next = !i_cyc ? IDLE : s_ack ? GAP : GNT_I;
            GNT_D:   w_next = !d_cyc ? IDLE : s_ack ? GAP : GNT_D;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_pri            <= 1'b0;
            r_conflict_count <= '0;
        end else begin
            r_state <= w_next;
            if (i_ack) r_pri <= 1'b0;
            if (d_ack) r_pri <= 1'b1;
            if (w_conflict) r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    // An acknowledge only reaches the master that is granted and still holding its cycle
    assign i_ack   = w_gi & i_cyc & s_ack;
    assign d_ack   = w_gd & d_cyc & s_ack;
    assign i_rty   = w_req_i & !i_ack;
    assign d_rty   = w_req_d & !d_ack;
    assign dat_s   = (w_gi | w_gd) ? s_dat_s : '0;
    assign s_cyc   = w_gi ? i_cyc   : w_gd ? d_cyc   : 1'b0;
    assign s_stb   = w_gi ? i_stb   : w_gd ? d_stb   : 1'b0;
    assign s_we    = w_gi ? i_we    : w_gd ? d_we    : 1'b0;
    assign s_adr   = w_gi ? i_adr   : w_gd ? d_adr   : '0;
    assign s_dat_m = w_gi ? i_dat_m : w_gd ? d_dat_m : '0;
    assign s_sel   = w_gi ? i_sel   : w_gd ? d_sel   : '0;
    assign conflict_count = r_conflict_count;
endmodule
